csh_data_slice: RTL and testbench

CSH_DATA_SLICE -- requirements
Module: csh_data_slice

---
 rtl/csh_data_slice.sv | 173 +++++++++++++++++
 tb/tb_csh_data_slice.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csh_data_slice.sv
// Multi-way cache data slice with odd parity, power-up clearing sweep,
// single-cycle wired-OR reads, sticky parity error capture and multi-way write detection.
module csh_data_slice #(
  parameter int WIDTH    = 9,
  parameter int WAYS     = 4,
  parameter int ADR_BITS = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADR_BITS-1:0] cache_adr,
  input  logic [WAYS-1:0]     way_sel_l,
  input  logic                cache_wr_l,
  input  logic                rd_en,
  input  logic [WIDTH-1:0]    mem_to_cache,
  input  logic                par_in,
  input  logic                err_clr,
  output logic [WIDTH-1:0]    cache_data,
  output logic                par_out,
  output logic                data_vld,
  output logic                par_err,
  output logic                err_sticky,
  output logic [ADR_BITS-1:0] err_adr,
  output logic                sel_err,
  output logic                init_busy
);

  localparam int DEPTH = 2 ** ADR_BITS;
  localparam int SC_W  = $clog2(WAYS + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADR_BITS-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]        mem_q [WAYS][DEPTH];

  logic [WIDTH:0]        rd_word_s;
  logic [SC_W-1:0]       sel_cnt_s;
  logic                  run_s;
  logic [WAYS-1:0]       wr_en_s;
  logic [ADR_BITS-1:0]   wr_adr_s;
  logic [WIDTH:0]        wr_word_s;

  logic [WIDTH-1:0]      cache_data_q;
  logic                  par_out_q;
  logic                  data_vld_q;
  logic                  par_err_q;
  logic [ADR_BITS-1:0]   rd_adr_q;
  logic                  err_sticky_q;
  logic [ADR_BITS-1:0]   err_adr_q;
  logic                  sel_err_q;

  // Odd parity: a healthy stored word has an odd number of ones.
  function automatic logic parity_ok(input logic [WIDTH:0] word);
    return ^word;
  endfunction

  // Wired-OR of all selected ways at the requested index, plus selected-way count.
  always_comb begin
    rd_word_s = '0;
    sel_cnt_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!way_sel_l[w]) begin
        rd_word_s = rd_word_s | mem_q[w][cache_adr];
        sel_cnt_s = sel_cnt_s + 1'b1;
      end else begin
        sel_cnt_s = sel_cnt_s;
      end
    end
  end

  // Sweep/run sequencing and array write selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_s     = 1'b0;
    wr_en_s   = '0;
    wr_adr_s  = cache_adr;
    wr_word_s = {par_in, mem_to_cache};
    case (state_q)
      ST_INIT: begin
        wr_en_s   = '1;
        wr_adr_s  = cnt_q;
        wr_word_s = {1'b1, {WIDTH{1'b0}}};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        run_s = 1'b1;
        if (!cache_wr_l && (sel_cnt_s == SC_W'(1))) begin
          wr_en_s = ~way_sel_l;
        end else begin
          wr_en_s = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and sweep counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage arrays; only the sweep ever clears them.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!reset && wr_en_s[w]) begin
        mem_q[w][wr_adr_s] <= wr_word_s;
      end
    end
  end

  // Read pipeline: samples the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_data_q <= '0;
      par_out_q    <= 1'b0;
      data_vld_q   <= 1'b0;
      par_err_q    <= 1'b0;
      rd_adr_q     <= '0;
    end else begin
      data_vld_q <= run_s && rd_en;
      par_err_q  <= run_s && rd_en && !parity_ok(rd_word_s);
      if (run_s && rd_en) begin
        {par_out_q, cache_data_q} <= rd_word_s;
        rd_adr_q                  <= cache_adr;
      end
    end
  end

  // Error reporting: a fresh fault outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
      err_adr_q    <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      sel_err_q <= run_s && !cache_wr_l && (sel_cnt_s > SC_W'(1));
      if (par_err_q && (!err_sticky_q || (run_s && err_clr))) begin
        err_sticky_q <= 1'b1;
        err_adr_q    <= rd_adr_q;
      end else if (run_s && err_clr) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign cache_data = cache_data_q;
  assign par_out    = par_out_q;
  assign data_vld   = data_vld_q;
  assign par_err    = par_err_q;
  assign err_sticky = err_sticky_q;
  assign err_adr    = err_adr_q;
  assign sel_err    = sel_err_q;
  assign init_busy  = (state_q == ST_INIT);

endmodule

// File: tb/tb_csh_data_slice.sv
// Scoreboard bench for csh_data_slice: stimulus pushes expected read beats from a
// behavioural array model; a negedge monitor checks beats, sticky error, sel_err and init timing.
module tb_csh_data_slice;
  localparam int WIDTH    = 9;
  localparam int WAYS     = 4;
  localparam int ADR_BITS = 9;
  localparam int DEPTH    = 512;

  logic                clk = 1'b0;
  logic                reset;
  logic [ADR_BITS-1:0] cache_adr;
  logic [WAYS-1:0]     way_sel_l;
  logic                cache_wr_l;
  logic                rd_en;
  logic [WIDTH-1:0]    mem_to_cache;
  logic                par_in;
  logic                err_clr;
  logic [WIDTH-1:0]    cache_data;
  logic                par_out;
  logic                data_vld;
  logic                par_err;
  logic                err_sticky;
  logic [ADR_BITS-1:0] err_adr;
  logic                sel_err;
  logic                init_busy;

  csh_data_slice #(.WIDTH(WIDTH), .WAYS(WAYS), .ADR_BITS(ADR_BITS)) dut (
    .clk(clk), .reset(reset), .cache_adr(cache_adr), .way_sel_l(way_sel_l),
    .cache_wr_l(cache_wr_l), .rd_en(rd_en), .mem_to_cache(mem_to_cache),
    .par_in(par_in), .err_clr(err_clr), .cache_data(cache_data), .par_out(par_out),
    .data_vld(data_vld), .par_err(par_err), .err_sticky(err_sticky),
    .err_adr(err_adr), .sel_err(sel_err), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0]    data;
    logic                par;
    logic                perr;
    logic [ADR_BITS-1:0] adr;
    int                  cyc;
  } rd_t;

  rd_t            exp_q[$];
  logic [WIDTH:0] model [WAYS][DEPTH];
  bit             in_init;
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endfunction

  // Monitor: reference state for outputs that are not tied to a single read beat.
  int                  busy_left = -1;
  bit                  known = 1'b0;
  logic [WIDTH-1:0]    last_data;
  logic                last_par;
  bit                  exp_sticky;
  logic [ADR_BITS-1:0] exp_eadr;
  bit                  pend_sel;
  rd_t                 mon_it;
  bit                  mon_have;

  always @(negedge clk) begin
    mon_have = 1'b0;
    if (known) begin
      chk("init_busy", {31'd0, init_busy}, {31'd0, busy_left > 0});
      chk("sel_err", {31'd0, sel_err}, {31'd0, pend_sel});
      chk("err_sticky", {31'd0, err_sticky}, {31'd0, exp_sticky});
      chk("err_adr", 32'(err_adr), 32'(exp_eadr));
      if (data_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", {31'd0, data_vld}, 32'd0);
        end else begin
          mon_it   = exp_q.pop_front();
          mon_have = 1'b1;
          chk("rd_latency", cyc, mon_it.cyc + 1);
          chk("cache_data", 32'(cache_data), 32'(mon_it.data));
          chk("par_out", {31'd0, par_out}, {31'd0, mon_it.par});
          chk("par_err", {31'd0, par_err}, {31'd0, mon_it.perr});
          last_data = mon_it.data;
          last_par  = mon_it.par;
        end
      end else begin
        chk("par_err_idle", {31'd0, par_err}, 32'd0);
        chk("hold_data", 32'(cache_data), 32'(last_data));
        chk("hold_par", {31'd0, par_out}, {31'd0, last_par});
        if (exp_q.size() > 0 && exp_q[0].cyc + 1 <= cyc) begin
          chk("missing_vld", {31'd0, data_vld}, 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
    if (reset) begin
      busy_left  = DEPTH;
      known      = 1'b1;
      last_data  = '0;
      last_par   = 1'b0;
      exp_sticky = 1'b0;
      exp_eadr   = '0;
      pend_sel   = 1'b0;
      exp_q.delete();
    end else begin
      pend_sel = (busy_left == 0) && !cache_wr_l && ($countones(~way_sel_l) >= 2);
      if (mon_have && mon_it.perr && (!exp_sticky || (busy_left == 0 && err_clr))) begin
        exp_sticky = 1'b1;
        exp_eadr   = mon_it.adr;
      end else if (busy_left == 0 && err_clr) begin
        exp_sticky = 1'b0;
      end
      if (busy_left > 0) busy_left--;
    end
  end

  task automatic step(input bit wr, input bit rd, input logic [WAYS-1:0] sel,
                      input logic [ADR_BITS-1:0] adr, input logic [WIDTH-1:0] d,
                      input logic p, input bit clr);
    rd_t            it;
    logic [WIDTH:0] word;
    cache_wr_l   = !wr;
    rd_en        = rd;
    way_sel_l    = sel;
    cache_adr    = adr;
    mem_to_cache = d;
    par_in       = p;
    err_clr      = clr;
    if (!in_init && !reset) begin
      if (rd) begin
        word = '0;
        for (int w = 0; w < WAYS; w++) if (!sel[w]) word = word | model[w][adr];
        it.data = word[WIDTH-1:0];
        it.par  = word[WIDTH];
        it.perr = (($countones(word) % 2) == 0);
        it.adr  = adr;
        it.cyc  = cyc;
        exp_q.push_back(it);
      end
      if (wr && $countones(~sel) == 1)
        for (int w = 0; w < WAYS; w++) if (!sel[w]) model[w][adr] = {p, d};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'hF, 9'd0, 9'd0, 1'b0, 1'b0);
  endtask

  task automatic garbage();
    step(1'($urandom), 1'($urandom), 4'($urandom), 9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom));
  endtask

  function automatic logic good_par(input logic [WIDTH-1:0] d);
    return ~(^d);
  endfunction

  task automatic full_init();
    for (int i = 0; i < DEPTH; i++) garbage();
    for (int w = 0; w < WAYS; w++)
      for (int a = 0; a < DEPTH; a++) model[w][a] = {1'b1, 9'd0};
    in_init = 1'b0;
  endtask

  logic [WAYS-1:0] rsel;

  initial begin
    in_init = 1'b1;
    reset   = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) garbage();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    full_init();

    // Every index reads back as cleared, mixing single and all-way selects.
    for (int i = 0; i < DEPTH; i++) begin
      rsel = (i % 8 == 7) ? 4'b0000 : ~(4'b0001 << (i % 4));
      step(1'b0, 1'b1, rsel, 9'(i), 9'd0, 1'b0, 1'b0);
    end

    step(1'b1, 1'b0, 4'b1011, 9'd7, 9'h1A5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1011, 9'd7, 9'd0, 1'b0, 1'b0);

    // Bad parity at index 3, then a second fault at 5 leaves err_adr alone.
    step(1'b1, 1'b0, 4'b1110, 9'd3, 9'h001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1110, 9'd3, 9'd0, 1'b0, 1'b0);
    idle();
    idle();
    chk("bad_read_adr", 32'(err_adr), 32'd3);
    step(1'b1, 1'b0, 4'b1101, 9'd5, 9'h003, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1101, 9'd5, 9'd0, 1'b0, 1'b0);
    idle();
    idle();
    chk("first_fault_kept", 32'(err_adr), 32'd3);
    step(1'b0, 1'b0, 4'hF, 9'd0, 9'd0, 1'b0, 1'b1);
    chk("err_clr", {31'd0, err_sticky}, 32'd0);

    // Clear coincident with a new fault: the fault reloads err_adr.
    step(1'b0, 1'b1, 4'b1101, 9'd5, 9'd0, 1'b0, 1'b0);
    idle();
    idle();
    step(1'b0, 1'b1, 4'b1110, 9'd3, 9'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'hF, 9'd0, 9'd0, 1'b0, 1'b1);
    idle();
    chk("clr_vs_fault_adr", 32'(err_adr), 32'd3);
    step(1'b0, 1'b0, 4'hF, 9'd0, 9'd0, 1'b0, 1'b1);

    // Illegal two-way write must not disturb either way.
    step(1'b1, 1'b0, 4'b1110, 9'd20, 9'h055, good_par(9'h055), 1'b0);
    step(1'b1, 1'b0, 4'b1011, 9'd20, 9'h0AA, good_par(9'h0AA), 1'b0);
    step(1'b1, 1'b0, 4'b1010, 9'd20, 9'h1FF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1110, 9'd20, 9'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1011, 9'd20, 9'd0, 1'b0, 1'b0);
    idle();

    // Read-first collision followed by back-to-back reads.
    step(1'b1, 1'b0, 4'b1110, 9'd9, 9'h111, good_par(9'h111), 1'b0);
    step(1'b1, 1'b1, 4'b1110, 9'd9, 9'h0F0, good_par(9'h0F0), 1'b0);
    step(1'b0, 1'b1, 4'b1110, 9'd9, 9'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b1110, 9'd9, 9'd0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) rsel = ~(4'b0001 << $urandom_range(0, 3));
      else rsel = 4'($urandom);
      step(1'($urandom), 1'($urandom), rsel, 9'($urandom_range(0, 15)),
           9'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
    end

    // Reset in RUN restarts the sweep and wipes previously written entries.
    reset   = 1'b1;
    in_init = 1'b1;
    idle();
    reset = 1'b0;
    full_init();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, ~(4'b0001 << (i % 4)), 9'(i), 9'd0, 1'b0, 1'b0);
    idle();
    idle();
    chk("queue_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
